// File: rtl/pkg_system_mdr.sv
`default_nettype none
// ============================================================================
// Module      : pkg_system_mdr
// Description : Shared widths and enumerations for the MDR readout path.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_system_mdr;

  // Operand width in bits and BCD result width (4 bits per digit).
  localparam int IVW = 8;
  localparam int FVW = 12;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requester identity.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_t;

  // Round-robin successor of a requester.
  function automatic req_t other_req(input req_t r);
    return (r == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_thto.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_thto
// Description : Combinational binary-to-BCD converter (shift-add-3). The
//               operand is treated as zero-extended into the BCD accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_thto
  import pkg_system_mdr::*;
(
  input  logic [IVW-1:0] i_bin,
  output logic [FVW-1:0] o_bcd
);

  localparam int c_DIGITS = FVW / 4;

  logic [FVW-1:0] w_acc;

  // Double-dabble: correct each digit >= 5 before shifting in the next bit.
  always_comb begin
    w_acc = '0;
    for (int i = IVW - 1; i >= 0; i--) begin
      for (int d = 0; d < c_DIGITS; d++) begin
        if (w_acc[d*4 +: 4] >= 4'd5) begin
          w_acc[d*4 +: 4] = w_acc[d*4 +: 4] + 4'd3;
        end
      end
      w_acc = {w_acc[FVW-2:0], i_bin[i]};
    end
    o_bcd = w_acc;
  end

endmodule
`default_nettype wire

// File: rtl/thto_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : thto_arbiter
// Description : Round-robin sharing of one bin_to_thto converter between the
//               MDR result (A) and remainder (B) requesters.
//               Optional macro THTO_SIGN_EN: two's-complement operands,
//               magnitude conversion and o_Neg_* sign outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module thto_arbiter
  import pkg_system_mdr::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_Start_A,
  input  logic           i_Start_B,
  input  logic [IVW-1:0] i_Data_A,
  input  logic [IVW-1:0] i_Data_B,
  output logic           o_Busy_A,
  output logic           o_Busy_B,
  output logic           o_Done_A,
  output logic           o_Done_B,
  output logic [FVW-1:0] o_Bcd_A,
  output logic [FVW-1:0] o_Bcd_B
`ifdef THTO_SIGN_EN
  ,
  output logic           o_Neg_A,
  output logic           o_Neg_B
`endif
);

  state_t         r_state;
  state_t         w_next_state;
  logic           r_pend_a;
  logic           r_pend_b;
  logic [IVW-1:0] r_data_a;
  logic [IVW-1:0] r_data_b;
  logic [IVW-1:0] r_op_reg;
  req_t           r_gnt;
  req_t           r_rr;

  logic           w_grant;
  req_t           w_grant_id;
  logic [IVW-1:0] w_grant_data;
  logic [IVW-1:0] w_op_next;
  logic           w_accept_a;
  logic           w_accept_b;
  logic           w_fin_a;
  logic           w_fin_b;
  logic [FVW-1:0] w_bcd;

  // A requester is busy while pending or while its conversion is in flight;
  // it frees up during DONE so it can restart on the done pulse.
  assign o_Busy_A   = r_pend_a | ((r_gnt == REQ_A) && (r_state == CONV));
  assign o_Busy_B   = r_pend_b | ((r_gnt == REQ_B) && (r_state == CONV));
  assign w_accept_a = i_Start_A & ~o_Busy_A;
  assign w_accept_b = i_Start_B & ~o_Busy_B;
  assign w_fin_a    = (r_state == CONV) && (r_gnt == REQ_A);
  assign w_fin_b    = (r_state == CONV) && (r_gnt == REQ_B);

  assign w_grant_data = (w_grant_id == REQ_A) ? r_data_a : r_data_b;

`ifdef THTO_SIGN_EN
  // Magnitude of a two's-complement operand; 8'h80 maps to unsigned 128.
  assign w_op_next = w_grant_data[IVW-1] ? (~w_grant_data + 1'b1) : w_grant_data;
`else
  assign w_op_next = w_grant_data;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state and grant decision.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_id   = r_gnt;
    case (r_state)
      IDLE: begin
        if (r_pend_a && r_pend_b) begin
          w_grant    = 1'b1;
          w_grant_id = r_rr;
        end else if (r_pend_a) begin
          w_grant    = 1'b1;
          w_grant_id = REQ_A;
        end else if (r_pend_b) begin
          w_grant    = 1'b1;
          w_grant_id = REQ_B;
        end
        if (w_grant) w_next_state = CONV;
      end
      CONV:    w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Per-requester pending flags and operand capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      if (w_accept_a) begin
        r_pend_a <= 1'b1;
        r_data_a <= i_Data_A;
      end else if (w_grant && (w_grant_id == REQ_A)) begin
        r_pend_a <= 1'b0;
      end
      if (w_accept_b) begin
        r_pend_b <= 1'b1;
        r_data_b <= i_Data_B;
      end else if (w_grant && (w_grant_id == REQ_B)) begin
        r_pend_b <= 1'b0;
      end
    end
  end

  // Shared converter operand, current grant and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op_reg <= '0;
      r_gnt    <= REQ_A;
      r_rr     <= REQ_A;
    end else if (w_grant) begin
      r_op_reg <= w_op_next;
      r_gnt    <= w_grant_id;
      r_rr     <= other_req(w_grant_id);
    end
  end

  bin_to_thto u_conv (
    .i_bin (r_op_reg),
    .o_bcd (w_bcd)
  );

  // Result capture and one-cycle done pulse for the granted requester.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_Done_A <= 1'b0;
      o_Done_B <= 1'b0;
      o_Bcd_A  <= '0;
      o_Bcd_B  <= '0;
    end else begin
      o_Done_A <= w_fin_a;
      o_Done_B <= w_fin_b;
      if (w_fin_a) o_Bcd_A <= w_bcd;
      if (w_fin_b) o_Bcd_B <= w_bcd;
    end
  end

`ifdef THTO_SIGN_EN
  // Sign capture; the operand register is stable while its owner is busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_Neg_A <= 1'b0;
      o_Neg_B <= 1'b0;
    end else begin
      if (w_fin_a) o_Neg_A <= r_data_a[IVW-1];
      if (w_fin_b) o_Neg_B <= r_data_b[IVW-1];
    end
  end
`endif

endmodule
`default_nettype wire
